time_disp_scan: RTL and testbench
=================================

TIME_DISP_SCAN -- requirements
Module: time_disp_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV_W, default 17, giving the scan prescaler width; one digit step occurs every 2^SCAN_DIV_W clocks.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on posedge Clk.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port hour  input  5  binary hour, valid range 0..23.
REQ-005 SHALL have port minute  input  6  binary minute, valid range 0..59.
REQ-006 SHALL have port second  input  6  binary second, valid range 0..59.
REQ-007 SHALL have port mode  input  2  display mode from the mode button counter; only bit 0 is used (0 = 24h, 1 = 12h).
REQ-008 SHALL have port an  output  8  digit enables, active-low; an[0] is the rightmost digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.
REQ-011 SHALL have port pm  output  1  high when 12h mode is active and the snapshot hour is 12..23.

Function
REQ-012 SHALL run a free-running SCAN_DIV_W-bit prescaler; a tick occurs in the cycle it equals all-ones.
REQ-013 SHALL hold a 3-bit digit index that steps 0,1,...,5,0 on each tick; indices 6 and 7 are unreachable, and an[7:6] SHALL always be 1.
REQ-014 SHALL snapshot hour, minute, second and mode[0] on the tick where the index wraps 5->0, so that every 6-digit frame shows one coherent time.
REQ-015 SHALL register an, seg and dp, which update in the cycle after a tick; exactly one of an[5:0] SHALL be low outside reset.
REQ-016 SHALL map digits as follows: index 0/1 = second units/tens, 2/3 = minute units/tens, 4/5 = displayed-hour units/tens.
REQ-017 SHALL compute the displayed hour in 24h mode as the snapshot hour.
REQ-018 SHALL compute the displayed hour in 12h mode as: 0 -> 12; 1..12 -> unchanged; 13..23 -> hour-12.
REQ-019 SHALL blank the hour tens digit (seg = all ones) in 12h mode when it is 0; in 24h mode the leading zero SHALL be shown.
REQ-020 SHALL show all six digits as a dash (only segment g lit) while any snapshot field is out of range (hour>23, minute>59 or second>59), with pm = 0.
REQ-021 SHALL register pm and update it only at the snapshot; a mode change mid-frame SHALL take effect at the next frame.
REQ-022 SHALL perform binary-to-BCD conversion combinationally on the snapshot values, with no multi-cycle conversion.

Reset
REQ-023 SHALL, while Rst is high, set the prescaler to 0, the index to 0, the snapshot to 0, an = 8'hFF, seg = 7'h7F, dp = 1 and pm = 0.
REQ-024 SHALL assert the first tick 2^SCAN_DIV_W-1 cycles after Rst deasserts, with index 0 enabled in the following cycle.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame with no partial update after Rst falls.

Configuration
REQ-026 SHALL, when macro BLINK_COLON_EN is defined, drive dp low on indices 2 and 4 while snapshot second[0] = 0 and high otherwise.
REQ-027 SHALL, when BLINK_COLON_EN is undefined, hold dp at 1 permanently, with no logic generated for it.

Structure
REQ-028 SHALL place the 7-segment codes for 0-9, the dash and blank, the mode encoding (MODE_24H = 0, MODE_12H = 1) and the digit count 6 in a shared package time_disp_pkg.
REQ-029 SHALL use one sub-module seg7_decode (4-bit code in, 7-bit active-low segments out, with codes 10 = dash and 15 = blank).

Verification (SCAN_DIV_W = 2)
REQ-030 SHALL cover: Rst held 3 cycles -> an = FF, seg = 7F, dp = 1, pm = 0; first an = FE occurs 4 cycles after release.
REQ-031 SHALL cover: hour = 0, minute = 5, second = 9, mode = 1 -> digits read "12 05 09" with tens digit "1" shown, pm = 0; mode = 0 -> "00 05 09".
REQ-032 SHALL cover: hour = 13, minute = 45, second = 30, mode = 3 -> "01" hour shown as blank + "1", pm = 1.
REQ-033 SHALL cover: hour changed from 9 to 10 at index 3 -> the current frame still shows 09 and the next frame shows 10.
REQ-034 SHALL cover: hour = 24 -> all six digits show seg = 7'h3F (dash), pm = 0; restoring hour = 23 recovers at the next frame.
REQ-035 SHALL cover: with BLINK_COLON_EN, second = 8 -> dp = 0 at indices 2 and 4 only; second = 9 -> dp = 1 throughout.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared constants for the multiplexed time display: segment codes, mode encoding,
// digit count and the binary/BCD helpers used on the snapshot values.
package time_disp_pkg;

    typedef enum logic {
        MODE_24H = 1'b0,
        MODE_12H = 1'b1
    } mode_e;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    // Midnight reads 12, afternoon hours fold down by twelve
    function automatic logic [4:0] disp_hour(input logic [4:0] h, input logic twelve);
        logic [4:0] d;
        if (!twelve) begin
            d = h;
        end else if (h == 5'd0) begin
            d = 5'd12;
        end else if (h > 5'd12) begin
            d = h - 5'd12;
        end else begin
            d = h;
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern; code 10 is a dash, 15 (and any
// other unused code) is blank.
module seg7_decode
    import time_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup from digit code to segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_disp_scan.sv
// Six-digit HH MM SS scanner for a multiplexed 7-segment display, with a 12h/24h
// mode and a frame-coherent snapshot. Define BLINK_COLON_EN to blink dp as a colon.
module time_disp_scan
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV_W = 17
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [1:0] mode,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       pm
);

    logic [SCAN_DIV_W-1:0] cnt_r;
    logic [2:0]            idx_r;
    logic [4:0]            hour_snap_r;
    logic [5:0]            min_snap_r;
    logic [5:0]            sec_snap_r;
    mode_e                 mode_snap_r;
    logic [7:0]            an_r;
    logic [6:0]            seg_r;
    logic                  pm_r;

    logic                  tick_s;
    logic                  valid_s;
    logic [5:0]            dhour_s;
    logic [3:0]            hour_tens_s;
    logic [3:0]            code_s;
    logic [6:0]            seg_dec_s;
    logic                  pm_next_s;
    logic                  mode_unused_s;

    assign mode_unused_s = mode[1];
    assign tick_s        = &cnt_r;
    assign valid_s       = (hour_snap_r <= 5'd23) && (min_snap_r <= 6'd59) && (sec_snap_r <= 6'd59);
    assign dhour_s       = {1'b0, disp_hour(hour_snap_r, mode_snap_r == MODE_12H)};
    assign hour_tens_s   = bcd_tens(dhour_s);
    assign pm_next_s     = mode[0] && (hour >= 5'd12) && (hour <= 5'd23)
                           && (minute <= 6'd59) && (second <= 6'd59);

    // Select the digit code for the current scan index from the snapshot
    always_comb begin
        code_s = CODE_BLANK;
        if (!valid_s) begin
            code_s = CODE_DASH;
        end else begin
            case (idx_r)
                3'd0: code_s = bcd_units(sec_snap_r);
                3'd1: code_s = bcd_tens(sec_snap_r);
                3'd2: code_s = bcd_units(min_snap_r);
                3'd3: code_s = bcd_tens(min_snap_r);
                3'd4: code_s = bcd_units(dhour_s);
                3'd5: begin
                    if ((mode_snap_r == MODE_12H) && (hour_tens_s == 4'd0)) begin
                        code_s = CODE_BLANK;
                    end else begin
                        code_s = hour_tens_s;
                    end
                end
                default: code_s = CODE_BLANK;
            endcase
        end
    end

    seg7_decode u_seg7_decode (
        .code (code_s),
        .seg  (seg_dec_s)
    );

    // Prescaler, scan index, frame snapshot and registered digit drive
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_r       <= '0;
            idx_r       <= 3'd0;
            hour_snap_r <= 5'd0;
            min_snap_r  <= 6'd0;
            sec_snap_r  <= 6'd0;
            mode_snap_r <= MODE_24H;
            an_r        <= 8'hFF;
            seg_r       <= 7'h7F;
            pm_r        <= 1'b0;
        end else begin
            cnt_r <= cnt_r + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
            if (tick_s) begin
                an_r  <= ~(8'd1 << idx_r);
                seg_r <= seg_dec_s;
                if (idx_r == 3'd5) begin
                    // Last digit of the frame is shown from the old snapshot while the new one loads
                    idx_r       <= 3'd0;
                    hour_snap_r <= hour;
                    min_snap_r  <= minute;
                    sec_snap_r  <= second;
                    mode_snap_r <= mode_e'(mode[0]);
                    pm_r        <= pm_next_s;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end
        end
    end

`ifdef BLINK_COLON_EN
    logic dp_r;

    // Colon dots on the minute and hour units digits, lit on even seconds
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dp_r <= 1'b1;
        end else if (tick_s) begin
            dp_r <= !(((idx_r == 3'd2) || (idx_r == 3'd4)) && !sec_snap_r[0]);
        end
    end

    assign dp = dp_r;
`else
    assign dp = 1'b1;
`endif

    assign an  = an_r;
    assign seg = seg_r;
    assign pm  = pm_r;

endmodule

// File: tb/tb_time_disp_scan.sv
// Directed bench for time_disp_scan at SCAN_DIV_W = 2 (one digit every 4 clocks).
module tb_time_disp_scan;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pm;

    int checks = 0;
    int errors = 0;

    logic [7:0] f_an  [6];
    logic [6:0] f_seg [6];
    logic       f_dp  [6];
    logic       f_pm;

    time_disp_scan #(.SCAN_DIV_W(2)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .hour   (hour),
        .minute (minute),
        .second (second),
        .mode   (mode),
        .an     (an),
        .seg    (seg),
        .dp     (dp),
        .pm     (pm)
    );

    always #5 Clk = ~Clk;

    function automatic logic exp_dp(input int k, input logic [5:0] s);
`ifdef BLINK_COLON_EN
        return ((k == 2 || k == 4) && !s[0]) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic wait_frame_start(input bit fresh);
        int n = 0;
        if (fresh) begin
            while (an == 8'hFE && n < 100) begin
                @(negedge Clk);
                n++;
            end
        end
        while (an != 8'hFE && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (an != 8'hFE) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout an=%h required fe", an);
        end
    endtask

    task automatic capture_frame(input bit fresh, input int chg_idx, input logic [4:0] chg_hour);
        wait_frame_start(fresh);
        f_pm = pm;
        for (int k = 0; k < 6; k++) begin
            if (k == chg_idx) hour = chg_hour;
            f_an[k]  = an;
            f_seg[k] = seg;
            f_dp[k]  = dp;
            repeat (4) @(negedge Clk);
        end
    endtask

    task automatic count_to_first_digit(input string name);
        int n = 0;
        while (an != 8'hFE && n < 50) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s first_digit_latency got %0d cycles required 4", name, n);
        end
    endtask

    task automatic test_reset();
        logic [6:0] ex [6];
        ex = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        Rst = 1'b1; hour = 5'd0; minute = 6'd0; second = 6'd0; mode = 2'd0;
        repeat (3) @(negedge Clk);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h required ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h required 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b required 1", dp); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm got %b required 0", pm); end
        Rst = 1'b0;
        count_to_first_digit("reset");
        capture_frame(1'b0, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL reset_frame seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
            checks++; if (f_dp[k] !== exp_dp(k, 6'd0)) begin errors++; $display("FAIL reset_frame dp[%0d] got %b", k, f_dp[k]); end
        end
    endtask

    task automatic test_12h_midnight();
        logic [6:0] ex [6];
        logic [7:0] ea;
        ex = '{7'h10, 7'h40, 7'h12, 7'h40, 7'h24, 7'h79};
        hour = 5'd0; minute = 6'd5; second = 6'd9; mode = 2'd1;
        capture_frame(1'b1, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            ea = ~(8'd1 << k);
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL mid12 seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
            checks++; if (f_an[k] !== ea) begin errors++; $display("FAIL mid12 an[%0d] got %h required %h", k, f_an[k], ea); end
            checks++; if (f_dp[k] !== exp_dp(k, second)) begin errors++; $display("FAIL mid12 dp[%0d] got %b", k, f_dp[k]); end
        end
        checks++; if (f_pm !== 1'b0) begin errors++; $display("FAIL mid12 pm got %b required 0", f_pm); end
    endtask

    task automatic test_24h_midnight();
        logic [6:0] ex [6];
        ex = '{7'h10, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40};
        hour = 5'd0; minute = 6'd5; second = 6'd9; mode = 2'd0;
        capture_frame(1'b1, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL mid24 seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
        end
        checks++; if (f_pm !== 1'b0) begin errors++; $display("FAIL mid24 pm got %b required 0", f_pm); end
    endtask

    task automatic test_12h_pm();
        logic [6:0] ex [6];
        ex = '{7'h40, 7'h30, 7'h12, 7'h19, 7'h79, 7'h7F};
        hour = 5'd13; minute = 6'd45; second = 6'd30; mode = 2'd3;
        capture_frame(1'b1, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL pm12 seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
            checks++; if (f_dp[k] !== exp_dp(k, second)) begin errors++; $display("FAIL pm12 dp[%0d] got %b", k, f_dp[k]); end
        end
        checks++; if (f_pm !== 1'b1) begin errors++; $display("FAIL pm12 pm got %b required 1", f_pm); end
    endtask

    task automatic test_snapshot_coherent();
        logic [6:0] ex1 [6];
        logic [6:0] ex2 [6];
        ex1 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h40};
        ex2 = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};
        hour = 5'd9; minute = 6'd0; second = 6'd0; mode = 2'd0;
        capture_frame(1'b1, 3, 5'd10);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex1[k]) begin errors++; $display("FAIL snap_cur seg[%0d] got %h required %h", k, f_seg[k], ex1[k]); end
        end
        capture_frame(1'b0, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex2[k]) begin errors++; $display("FAIL snap_next seg[%0d] got %h required %h", k, f_seg[k], ex2[k]); end
        end
    endtask

    task automatic test_out_of_range();
        logic [6:0] ex [6];
        ex = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h79};
        hour = 5'd24; minute = 6'd0; second = 6'd0; mode = 2'd1;
        capture_frame(1'b1, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== 7'h3F) begin errors++; $display("FAIL dash seg[%0d] got %h required 3f", k, f_seg[k]); end
        end
        checks++; if (f_pm !== 1'b0) begin errors++; $display("FAIL dash pm got %b required 0", f_pm); end
        hour = 5'd23;
        capture_frame(1'b1, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL recover seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
        end
        checks++; if (f_pm !== 1'b1) begin errors++; $display("FAIL recover pm got %b required 1", f_pm); end
    endtask

    task automatic test_dp();
        logic [6:0] ex [6];
        ex = '{7'h00, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79};
        hour = 5'd12; minute = 6'd0; second = 6'd8; mode = 2'd0;
        for (int pass = 0; pass < 2; pass++) begin
            capture_frame(1'b1, -1, 5'd0);
            for (int k = 0; k < 6; k++) begin
                checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL dp_sec%0d seg[%0d] got %h required %h", second, k, f_seg[k], ex[k]); end
                checks++; if (f_dp[k] !== exp_dp(k, second)) begin errors++; $display("FAIL dp_sec%0d dp[%0d] got %b required %b", second, k, f_dp[k], exp_dp(k, second)); end
            end
            second = 6'd9;
            ex[0] = 7'h10;
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] ex [6];
        ex = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        hour = 5'd23; minute = 6'd59; second = 6'd59; mode = 2'd1;
        wait_frame_start(1'b1);
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midrst_an got %h required ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h required 7f", seg); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL midrst_pm got %b required 0", pm); end
        Rst = 1'b0;
        count_to_first_digit("midrst");
        capture_frame(1'b0, -1, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++; if (f_seg[k] !== ex[k]) begin errors++; $display("FAIL midrst_frame seg[%0d] got %h required %h", k, f_seg[k], ex[k]); end
        end
        checks++; if (f_pm !== 1'b0) begin errors++; $display("FAIL midrst_frame pm got %b required 0", f_pm); end
    endtask

    initial begin
        test_reset();
        test_12h_midnight();
        test_24h_midnight();
        test_12h_pm();
        test_snapshot_coherent();
        test_out_of_range();
        test_dp();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
